// File: rtl/hex_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_driver_pkg
// Description : Shared types, constants and helpers for the hex scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_scan_driver_pkg;

    // Width of one hex digit as presented to the seven-segment decoder
    localparam int c_NIBBLE_W = 4;

    // Upper bound on digit count supported by the blank-mask helper
    localparam int c_MAX_DIGITS = 64;

    // Per-slot scan state: all digits dark, or the selected digit lit
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // All-ones enable pattern (every active-low digit enable deasserted);
    // callers size-cast the result down to their own digit count.
    function automatic logic [c_MAX_DIGITS-1:0] blank_mask();
        return '1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_scan_driver_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_driver_slot_timer
// Description : Prescaler and digit-index counter for the scan driver. Emits
//               the current slot cycle, digit index and end-of-slot /
//               end-of-frame strobes (combinational from the counters).
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_driver_slot_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int PW         = $clog2(SCAN_DIV),
    parameter int IW         = $clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [PW-1:0] o_slot_cycle,
    output logic [IW-1:0] o_idx,
    output logic          o_end_slot,
    output logic          o_end_frame
);

    localparam logic [PW-1:0] c_LAST_P   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] c_LAST_IDX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] r_p;
    logic [IW-1:0] r_idx;
    logic          w_end_slot;
    logic          w_end_frame;

    assign w_end_slot  = (r_p == c_LAST_P);
    assign w_end_frame = w_end_slot && (r_idx == c_LAST_IDX);

    // Prescaler wraps every slot; digit index advances on each wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_idx <= '0;
        end else if (w_end_slot) begin
            r_p   <= '0;
            r_idx <= w_end_frame ? '0 : r_idx + 1'b1;
        end else begin
            r_p   <= r_p + 1'b1;
        end
    end

    assign o_slot_cycle = r_p;
    assign o_idx        = r_idx;
    assign o_end_slot   = w_end_slot;
    assign o_end_frame  = w_end_frame;

endmodule
`default_nettype wire

// File: rtl/hex_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_driver
// Description : Time-multiplexed hex display scanner with per-slot blanking
//               guard and frame-aligned double-buffered value commit.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_driver
    import hex_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [c_NIBBLE_W*NUM_DIGITS-1:0] value,
    output logic [c_NIBBLE_W-1:0]            val,
    output logic [NUM_DIGITS-1:0]            digit_en_n,
    output logic                             pending,
    output logic                             frame_done
);

    localparam int c_PW = $clog2(SCAN_DIV);
    localparam int c_IW = $clog2(NUM_DIGITS);
    localparam int c_VW = c_NIBBLE_W * NUM_DIGITS;

    localparam bit                  c_NO_BLANK   = (BLANK_CYCLES == 0);
    // Slot cycle on which the blanking guard ends (unused when c_NO_BLANK)
    localparam logic [c_PW-1:0]     c_BLANK_LAST = c_PW'(BLANK_CYCLES - 1);
    localparam scan_state_t         c_RST_STATE  = c_NO_BLANK ? ST_DRIVE : ST_BLANK;
    localparam logic [NUM_DIGITS-1:0] c_BLANK_MASK = NUM_DIGITS'(blank_mask());

    logic [c_PW-1:0]       w_slot;
    logic [c_IW-1:0]       w_idx;
    logic                  w_end_slot;
    logic                  w_end_frame;
    logic [c_NIBBLE_W-1:0] w_nib;
    logic [NUM_DIGITS-1:0] w_onecold;

    scan_state_t           r_state;
    logic [c_VW-1:0]       r_shadow;
    logic [c_VW-1:0]       r_active;
    logic                  r_pending;
    logic [c_NIBBLE_W-1:0] r_val;
    logic [NUM_DIGITS-1:0] r_en_n;
    logic                  r_frame_done;

    hex_scan_driver_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .PW         (c_PW),
        .IW         (c_IW)
    ) u_slot_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_slot_cycle (w_slot),
        .o_idx        (w_idx),
        .o_end_slot   (w_end_slot),
        .o_end_frame  (w_end_frame)
    );

    // Select the committed nibble and one-cold enable for the current digit
    always_comb begin
        w_nib     = '0;
        w_onecold = c_BLANK_MASK;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (w_idx == c_IW'(d)) begin
                w_nib        = r_active[d*c_NIBBLE_W +: c_NIBBLE_W];
                w_onecold[d] = 1'b0;
            end
        end
    end

    // Scan FSM (state tracks the slot cycle held in the prescaler), registered
    // outputs, and the shadow/active double buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_RST_STATE;
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_val        <= '0;
            r_en_n       <= c_BLANK_MASK;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    // Dark while the new nibble settles on the decoder input
                    r_en_n <= c_BLANK_MASK;
                    r_val  <= w_nib;
                    if (w_slot == c_BLANK_LAST) begin
                        r_state <= ST_DRIVE;
                    end
                end
                default: begin
                    r_en_n <= w_onecold;
                    // Without a guard the nibble must change on the first slot cycle
                    if (c_NO_BLANK && (w_slot == '0)) begin
                        r_val <= w_nib;
                    end
                    if (w_end_slot && !c_NO_BLANK) begin
                        r_state <= ST_BLANK;
                    end
                end
            endcase

            r_frame_done <= w_end_frame;

            // A load coinciding with the frame end bypasses the shadow so the
            // newest value is never left stranded for an extra frame
            if (load) begin
                r_shadow <= value;
                if (w_end_frame) begin
                    r_active  <= value;
                    r_pending <= 1'b0;
                end else begin
                    r_pending <= 1'b1;
                end
            end else if (w_end_frame && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    assign val        = r_val;
    assign digit_en_n = r_en_n;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_scan_driver
// Description : Scoreboard bench for hex_scan_driver (4 digits, 8-cycle
//               slots, 2-cycle blanking guard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  val;
    logic [3:0]  digit_en_n;
    logic        pending;
    logic        frame_done;

    hex_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .val        (val),
        .digit_en_n (digit_en_n),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ecnt     = -1;   // index of the most recent rising edge since reset

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] val;
    } slot_t;

    slot_t      exp_q[$];
    logic [3:0] en_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= -1;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected driven slots for one frame: digit d shows nibble d of disp
    task automatic push_frame(input logic [15:0] disp, input int ndig);
        slot_t s;
        for (int d = 0; d < ndig; d++) begin
            s.en  = en_tab[d];
            s.val = disp[d*4 +: 4];
            exp_q.push_back(s);
        end
    endtask

    task automatic wait_neg(input int k);
        while (ecnt < k) @(negedge clk);
    endtask

    // load sampled on rising edge k
    task automatic do_load(input int k, input logic [15:0] v);
        wait_neg(k - 1);
        load  = 1'b1;
        value = v;
        wait_neg(k);
        load  = 1'b0;
    endtask

    // Monitor: each lit-digit interval is matched against the next expected slot
    logic  in_drive  = 1'b0;
    int    drive_len = 0;
    slot_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_drive  = 1'b0;
            drive_len = 0;
        end else if (digit_en_n != 4'hF) begin
            if (!in_drive) begin
                in_drive  = 1'b1;
                drive_len = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_slot: got en=%b val=%h, none expected", digit_en_n, val);
                    cur.en  = 4'hF;
                    cur.val = 4'h0;
                end else begin
                    cur = exp_q.pop_front();
                    chk("slot_en", 32'(digit_en_n), 32'(cur.en));
                    chk("slot_val", 32'(val), 32'(cur.val));
                end
            end else begin
                drive_len++;
                chk("hold_en", 32'(digit_en_n), 32'(cur.en));
                chk("hold_val", 32'(val), 32'(cur.val));
            end
        end else if (in_drive) begin
            in_drive = 1'b0;
            chk("drive_len", 32'(drive_len), 32'd6);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected display sequence, frame by frame
        push_frame(16'h0000, 4);   // before any commit
        push_frame(16'h1234, 4);
        push_frame(16'hABCD, 4);
        push_frame(16'h0F0F, 4);
        push_frame(16'h5555, 4);   // bypass commit
        push_frame(16'h2222, 4);   // last of back-to-back loads
        push_frame(16'h2222, 2);   // cut short by reset during digit 1
        push_frame(16'h0000, 4);   // after reset

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(digit_en_n), 32'hF);
        chk("rst_val", 32'(val), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        wait_neg(1);
        chk("c1_en", 32'(digit_en_n), 32'hF);
        wait_neg(2);
        chk("c2_en", 32'(digit_en_n), 32'hE);
        chk("c2_val", 32'(val), 32'h0);

        // First load and frame-end commit
        do_load(3, 16'h1234);
        chk("load_pending", 32'(pending), 32'h1);
        wait_neg(30);
        chk("c30_frame_done", 32'(frame_done), 32'h0);
        chk("c30_pending", 32'(pending), 32'h1);
        wait_neg(31);
        chk("c31_frame_done", 32'(frame_done), 32'h1);
        chk("c31_pending", 32'(pending), 32'h0);

        // ABCD shown in frame 2; 0F0F loaded mid-frame during digit 2
        do_load(40, 16'hABCD);
        chk("abcd_pending", 32'(pending), 32'h1);
        do_load(82, 16'h0F0F);
        chk("0f0f_pending", 32'(pending), 32'h1);
        wait_neg(95);
        chk("c95_frame_done", 32'(frame_done), 32'h1);
        chk("c95_pending", 32'(pending), 32'h0);

        // Load exactly on the frame end
        do_load(127, 16'h5555);
        chk("bypass_pending", 32'(pending), 32'h0);
        chk("bypass_frame_done", 32'(frame_done), 32'h1);

        // Back-to-back loads
        wait_neg(139);
        load  = 1'b1;
        value = 16'h1111;
        wait_neg(140);
        chk("b2b_pending1", 32'(pending), 32'h1);
        value = 16'h2222;
        wait_neg(141);
        load  = 1'b0;
        chk("b2b_pending2", 32'(pending), 32'h1);

        // Pending load then asynchronous reset during drive of digit 1
        do_load(201, 16'h9999);
        chk("pre_rst_pending", 32'(pending), 32'h1);
        wait_neg(203);
        chk("pre_rst_en", 32'(digit_en_n), 32'hD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", 32'(digit_en_n), 32'hF);
        chk("async_rst_val", 32'(val), 32'h0);
        chk("async_rst_pending", 32'(pending), 32'h0);
        chk("async_rst_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        wait_neg(0);
        chk("post_rst_c0_en", 32'(digit_en_n), 32'hF);
        wait_neg(2);
        chk("post_rst_c2_en", 32'(digit_en_n), 32'hE);
        chk("post_rst_c2_val", 32'(val), 32'h0);
        wait_neg(33);
        chk("post_rst_pending", 32'(pending), 32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed scanner that sits directly upstream of the per-digit hex seven-segment decoder. It holds a multi-digit hex value and presents one 4-bit nibble at a time on `val`, which feeds the decoder. It drives a matching active-low digit enable and inserts a blanking guard at each digit change to prevent ghosting. New values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes two values.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits; legal range is 2 or more.
- `SCAN_DIV`, 50000: clock cycles per digit slot; legal range is 2 or more.
- `BLANK_CYCLES`, 2: cycles at the start of each slot with all digits disabled; legal range is 0 to SCAN_DIV-1.
- `clk`  in  1  the single clock; all state is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `load`  in  1  capture `value` into the shadow register on this cycle.
- `value`  in  4*NUM_DIGITS  hex value; digit 0 is `value[3:0]` and is the rightmost digit.
- `val`  out  4  nibble of the active digit, wired to the decoder input.
- `digit_en_n`  out  NUM_DIGITS  one-cold digit enable (active-low); all ones means blanked.
- `pending`  out  1  the shadow holds a value not yet committed.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Registers:
  - prescaler `p`, counting 0 to SCAN_DIV-1;
  - digit index `idx`, counting 0 to NUM_DIGITS-1;
  - `shadow` and `active`, each 4*NUM_DIGITS bits;
  - `pending`.
- Two-state FSM per slot:
  - BLANK while p < BLANK_CYCLES;
  - DRIVE for the remainder of the slot.
  - BLANK_CYCLES=0 means the FSM is never in BLANK.
- BLANK: `digit_en_n` is all ones, and `val` is updated to `active[4*idx +: 4]`.
- DRIVE: `digit_en_n[idx]`=0 and all other bits are 1; `val` is held constant.
- End of slot (p=SCAN_DIV-1): p wraps to 0 and idx increments.
- End of frame (additionally idx=NUM_DIGITS-1):
  - idx wraps to 0;
  - `frame_done`=1 for that cycle;
  - if `pending`=1, then `active`<=`shadow` and `pending`<=0.
- `load`=1: `shadow`<=`value` and `pending`<=1. Back-to-back loads overwrite the shadow; the last one wins.
- `load` on the same cycle as the end of frame: the incoming `value` is committed directly to `active` (bypass), and `pending` ends at 0.
- Reset (asynchronous, any time including mid-slot), all outputs and registers go to:
  - `digit_en_n` all ones;
  - `val`=0;
  - `frame_done`=0;
  - `pending`=0;
  - `shadow`=0, `active`=0;
  - p=0, idx=0, FSM in BLANK (or DRIVE if BLANK_CYCLES=0).

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- After `rst_n` deasserts, the first clock edge is slot-cycle 0 of digit 0.
- Within a slot, at slot-cycle c:
  - `digit_en_n` is blanked for c < BLANK_CYCLES;
  - the digit is enabled for c from BLANK_CYCLES to SCAN_DIV-1.
- `val` is stable for at least one cycle before its enable asserts whenever BLANK_CYCLES is 1 or more.
- Frame length is NUM_DIGITS*SCAN_DIV cycles.
- Load-to-display latency is at most one full frame plus one slot: the value is committed at the frame end and appears in the next digit-0 slot.
- The display after reset shows 0 until the first committed load.

## Structure
- Shared package holds:
  - the FSM state enum (BLANK, DRIVE);
  - the nibble width constant (4);
  - the all-ones blank-mask helper for `digit_en_n`.
- Natural sub-module: `slot_timer`, the prescaler plus idx counter, emitting slot-cycle, idx, and the end-of-slot and end-of-frame strobes.
- The decoder is instantiated by the parent, not inside this block.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
- **Reset values:** hold reset low, then release. `digit_en_n`=4'b1111, `val`=0, `pending`=0, `frame_done`=0. Slot-cycle 2 gives `digit_en_n`=4'b1110 with `val`=0.
- **First load:** `load` with 16'h1234 at cycle 3 gives `pending`=1. At cycle 31, `frame_done`=1 and `pending` goes to 0. Slots then show `val` 4, 3, 2, 1 with enables 1110, 1101, 1011, 0111 during slot-cycles 2 to 7.
- **No tearing:** with 16'hABCD displayed, load 16'h0F0F during the digit-2 slot. Digits 2 and 3 still show C and A. The next frame shows F, 0, F, 0.
- **Simultaneous load and frame end:** assert `load` with 16'h5555 exactly at cycle 31. `pending` is 0 after the edge, and the next digit-0 slot shows `val`=5.
- **Back-to-back loads:** 16'h1111 then 16'h2222 on consecutive cycles. Only 2222 is ever displayed.
- **Mid-slot reset:** assert `rst_n`=0 during DRIVE of digit 1. `digit_en_n` goes to 1111 immediately, without waiting for a clock edge. After release, scanning restarts at digit 0 and the display shows 0.
